// File: rtl/timer_ctrl_if.sv
// Register bus between a host and timer_ctrl.
// Handshake: wr_en and rd_en are single-cycle strobes with no backpressure;
// the slave always accepts. A rd_en sampled on a rising edge produces
// rvalid=1 for exactly one cycle after that edge, with rdata valid alongside.
// rdata holds its last value while rvalid=0.
interface timer_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/timer_ctrl.sv
// Register front-end for NCH timer channels: per-channel CTRL, TERMCOUNT,
// CURRCOUNT and STAT registers, single-cycle trigger pulses to the timers,
// sticky pending flags and a priority-encoded combined interrupt.
module timer_ctrl #(
  parameter int NCH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_ctrl_if.slave          bus,
  output logic [NCH-1:0]       ro_trig_start,
  output logic [NCH-1:0]       ro_trig_halt,
  output logic [NCH-1:0]       ro_mode,
  output logic [32*NCH-1:0]    ro_termcount,
  input  logic [NCH-1:0]       rf_status,
  input  logic [32*NCH-1:0]    rf_currcount,
  input  logic [NCH-1:0]       rf_int,
  output logic                 irq,
  output logic [1:0]           irq_id
);

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_TERM = 2'd1;
  localparam logic [1:0] REG_CURR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  logic [1:0]                ch;
  logic [1:0]                reg_sel;

  logic [NCH-1:0]            mode_q, mode_d;
  logic [NCH-1:0]            ie_q, ie_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            start_q, start_d;
  logic [NCH-1:0]            halt_q, halt_d;
  logic [NCH-1:0][31:0]      term_q, term_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;
  logic [NCH-1:0]            clr;
  logic [NCH-1:0]            active;

  assign ch      = bus.addr[3:2];
  assign reg_sel = bus.addr[1:0];

  // Next-state for all registers: writes, write-1 actions, pending set/clear and read capture.
  always_comb begin
    mode_d   = mode_q;
    ie_d     = ie_q;
    term_d   = term_q;
    start_d  = '0;
    halt_d   = '0;
    clr      = '0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    if (bus.wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          mode_d[ch]  = bus.wdata[0];
          ie_d[ch]    = bus.wdata[1];
          // Halt takes precedence: a simultaneous start request is dropped.
          halt_d[ch]  = bus.wdata[3];
          start_d[ch] = bus.wdata[2] & ~bus.wdata[3];
        end
        REG_TERM: term_d[ch] = bus.wdata;
        REG_STAT: clr[ch] = bus.wdata[1];
        default: ;
      endcase
    end

    // A terminal-count pulse in the same cycle as a clear keeps the flag set.
    pend_d = (pend_q & ~clr) | rf_int;

    // Reads sample the registered state, so a same-cycle write is not visible yet.
    if (bus.rd_en) begin
      rvalid_d = 1'b1;
      case (reg_sel)
        REG_CTRL: rdata_d = {30'd0, ie_q[ch], mode_q[ch]};
        REG_TERM: rdata_d = term_q[ch];
        REG_CURR: rdata_d = rf_currcount[{ch, 5'd0} +: 32];
        default:  rdata_d = {30'd0, pend_q[ch], rf_status[ch]};
      endcase
    end
  end

  // State register with synchronous clear; bus and rf_int are ignored while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= '0;
      ie_q     <= '0;
      term_q   <= '0;
      pend_q   <= '0;
      start_q  <= '0;
      halt_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      ie_q     <= ie_d;
      term_q   <= term_d;
      pend_q   <= pend_d;
      start_q  <= start_d;
      halt_q   <= halt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Interrupt: OR of enabled pending flags, id is the lowest such channel.
  always_comb begin
    active = pend_q & ie_q;
    irq    = |active;
    irq_id = 2'd0;
    for (int n = NCH - 1; n >= 0; n--) begin
      if (active[n]) irq_id = 2'(n);
    end
  end

  // A reset arriving the cycle after a start write cancels that start pulse.
  assign ro_trig_start = start_q & ~{NCH{reset}};
  assign ro_trig_halt  = halt_q;
  assign ro_mode       = mode_q;
  assign ro_termcount  = term_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: randomized and directed bus traffic against a
// behavioural model; read data goes through an expected-value queue.
module tb_timer_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ro_trig_start, ro_trig_halt, ro_mode;
  logic [127:0] ro_termcount;
  logic [3:0]   rf_status;
  logic [127:0] rf_currcount;
  logic [3:0]   rf_int;
  logic         irq;
  logic [1:0]   irq_id;

  always #5 clk = ~clk;

  timer_ctrl_if bus ();

  timer_ctrl #(.NCH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .ro_trig_start (ro_trig_start),
    .ro_trig_halt  (ro_trig_halt),
    .ro_mode       (ro_mode),
    .ro_termcount  (ro_termcount),
    .rf_status     (rf_status),
    .rf_currcount  (rf_currcount),
    .rf_int        (rf_int),
    .irq           (irq),
    .irq_id        (irq_id)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]   start;
    logic [3:0]   halt;
    logic [3:0]   mode;
    logic         irq;
    logic [1:0]   irq_id;
    logic [127:0] term;
    logic         rvalid;
    logic [31:0]  rdata;
  } exp_t;

  logic [3:0]  m_mode, m_ie, m_pend;
  logic [31:0] m_term [4];
  logic [31:0] m_rdata;

  logic [31:0] exp_q [$];
  exp_t        out_q [$];
  exp_t        prev_e;
  bit          have_prev = 0;
  bit          fix_cc = 0;
  logic [127:0] cc_val = '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic w, input logic rd,
                       input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ri);
    exp_t        e;
    logic [31:0] rv;
    logic [3:0]  clr;
    int          ch;
    int          lowest;
    @(posedge clk);
    #1;
    // Outputs produced by the previous cycle's inputs are now on the pins.
    if (have_prev) begin
      if (r) prev_e.start = '0;
      out_q.push_back(prev_e);
    end
    reset         = r;
    bus.wr_en     = w;
    bus.rd_en     = rd;
    bus.addr      = a;
    bus.wdata     = wd;
    rf_int        = ri;
    rf_status     = 4'($urandom_range(0, 15));
    rf_currcount  = fix_cc ? cc_val : {$urandom, $urandom, $urandom, $urandom};

    ch = int'(a[3:2]);
    e  = '0;
    if (r) begin
      m_mode = '0; m_ie = '0; m_pend = '0; m_rdata = '0;
      for (int i = 0; i < 4; i++) m_term[i] = '0;
    end else begin
      if (rd) begin
        case (a[1:0])
          2'd0: rv = {30'd0, m_ie[ch], m_mode[ch]};
          2'd1: rv = m_term[ch];
          2'd2: rv = rf_currcount[ch*32 +: 32];
          default: rv = {30'd0, m_pend[ch], rf_status[ch]};
        endcase
        exp_q.push_back(rv);
        e.rvalid = 1'b1;
        m_rdata  = rv;
      end
      clr = '0;
      if (w) begin
        case (a[1:0])
          2'd0: begin
            m_mode[ch] = wd[0];
            m_ie[ch]   = wd[1];
            if (wd[3])      e.halt[ch]  = 1'b1;
            else if (wd[2]) e.start[ch] = 1'b1;
          end
          2'd1: m_term[ch] = wd;
          2'd3: clr[ch] = wd[1];
          default: ;
        endcase
      end
      for (int i = 0; i < 4; i++) m_pend[i] = ri[i] ? 1'b1 : (clr[i] ? 1'b0 : m_pend[i]);
    end
    e.rdata = m_rdata;
    e.mode  = m_mode;
    e.term  = {m_term[3], m_term[2], m_term[1], m_term[0]};
    lowest  = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_ie[i]) lowest = i;
    e.irq    = (lowest >= 0);
    e.irq_id = (lowest >= 0) ? 2'(lowest) : 2'd0;
    prev_e    = e;
    have_prev = 1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd);
    drive(1'b0, 1'b1, 1'b0, a, wd, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b0, 1'b0, 1'b1, a, 32'd0, 4'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t me;
  always @(negedge clk) begin
    if (out_q.size() > 0) begin
      me = out_q.pop_front();
      chk("trig_start", ro_trig_start, me.start);
      chk("trig_halt",  ro_trig_halt,  me.halt);
      chk("mode",       ro_mode,       me.mode);
      chk("termcount",  ro_termcount,  me.term);
      chk("irq",        irq,           me.irq);
      chk("irq_id",     irq_id,        me.irq_id);
      chk("rvalid",     bus.rvalid,    me.rvalid);
      if (bus.rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rdata_unexpected: got %0h expected no read", bus.rdata);
        end else begin
          chk("rdata", bus.rdata, exp_q.pop_front());
        end
      end else begin
        chk("rdata_hold", bus.rdata, me.rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; bus.wr_en = 0; bus.rd_en = 0; bus.addr = '0; bus.wdata = '0;
    rf_int = '0; rf_status = '0; rf_currcount = '0;
    m_mode = '0; m_ie = '0; m_pend = '0; m_rdata = '0;
    for (int i = 0; i < 4; i++) m_term[i] = '0;

    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    idle();

    // termcount/start on channel 2 with continuous mode
    wr(4'b10_01, 32'h0000_0010);
    wr(4'b10_00, 32'h0000_0005);
    idle();
    // start and halt together on channel 1
    wr(4'b01_00, 32'h0000_000C);
    idle();
    // interrupts on channels 1 and 3, then clear one at a time
    wr(4'b01_00, 32'h2);
    wr(4'b11_00, 32'h2);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'b1010);
    idle();
    wr(4'b01_11, 32'h2);
    idle();
    wr(4'b11_11, 32'h2);
    idle();
    // masking ie keeps pending
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'b0010);
    wr(4'b01_00, 32'h0);
    rd(4'b01_11);
    wr(4'b01_00, 32'h2);
    // set beats clear in the same cycle
    drive(1'b0, 1'b1, 1'b0, 4'b00_11, 32'h2, 4'b0001);
    rd(4'b00_11);
    // CURRCOUNT pass-through and CTRL readback
    fix_cc = 1; cc_val = 128'h0000_1234;
    rd(4'b00_10);
    fix_cc = 0;
    wr(4'b00_00, 32'hF);
    rd(4'b00_00);
    // same-cycle read and write of TERMCOUNT
    wr(4'b11_01, 32'hAAAA_5555);
    drive(1'b0, 1'b1, 1'b1, 4'b11_01, 32'h1357_9BDF, 4'd0);
    rd(4'b11_01);
    // reset right after a start write
    wr(4'b00_00, 32'h4);
    drive(1'b1, 1'b1, 1'b1, 4'b00_01, 32'hFFFF, 4'hF);
    for (int a = 0; a < 16; a++) rd(4'(a));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ri;
      for (int i = 0; i < 4; i++) ri[i] = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom,
            ri);
    end

    idle();
    idle();
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL read_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
